// File: rtl/float_to_ieee_pkg.sv
// Shared widths, internal float layout and state/case encodings for the
// internal-float to IEEE-754 output converter.
package float_to_ieee_pkg;

    localparam int Nm      = 23;
    localparam int Ne      = 8;
    localparam int BIAS    = 2**(Ne-1) - 1;
    localparam int EXP_MAX = 2**Ne - 1;

    // Internal operand: signed biased exponent, explicit hidden bit at mant[Nm]
    typedef struct packed {
        logic          s;
        logic [Ne:0]   exp;
        logic [Nm:0]   mant;
    } float_t;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        OUT
    } state_t;

    typedef enum logic [2:0] {
        FMT_ZERO,
        FMT_FLUSH,
        FMT_INF,
        FMT_DENORM,
        FMT_NORMAL
    } fmt_sel_t;

endpackage

// File: rtl/float_to_ieee_fmt.sv
// Final IEEE pack: builds the output word and status flags from the
// normalised sign/exponent/fraction and the classification chosen by the FSM.
module float_ieee_fmt #(
    parameter int Nm = 23,
    parameter int Ne = 8
) (
    input  logic             s_i,
    input  logic [Ne-1:0]    exp_i,
    input  logic [Nm-1:0]    frac_i,
    input  logic [2:0]       sel_i,
    output logic [Ne+Nm:0]   word_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             unf_o
);
    import float_to_ieee_pkg::*;

    fmt_sel_t sel;
    assign sel = fmt_sel_t'(sel_i);

    always_comb begin
        word_o = '0;
        zero_o = 1'b0;
        ovf_o  = 1'b0;
        unf_o  = 1'b0;
        case (sel)
            FMT_ZERO: begin
                word_o = {s_i, {Ne{1'b0}}, {Nm{1'b0}}};
                zero_o = 1'b1;
            end
            FMT_FLUSH: begin
                word_o = {s_i, {Ne{1'b0}}, {Nm{1'b0}}};
                zero_o = 1'b1;
                unf_o  = 1'b1;
            end
            FMT_INF: begin
                word_o = {s_i, {Ne{1'b1}}, {Nm{1'b0}}};
                ovf_o  = 1'b1;
            end
            FMT_DENORM: begin
                word_o = {s_i, {Ne{1'b0}}, frac_i};
                unf_o  = 1'b1;
            end
            default: begin
                word_o = {s_i, exp_i, frac_i};
            end
        endcase
    end

endmodule

// File: rtl/float_to_ieee.sv
// Internal float -> IEEE-754 converter: accepts one operand, normalises it
// with one left shift per cycle, then presents the packed word until taken.
module float_to_ieee #(
    parameter int Nm = 23,
    parameter int Ne = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Nm+Ne+2:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Ne+Nm:0]     out_data,
    output logic               out_zero,
    output logic               out_ovf,
    output logic               out_unf
);
    import float_to_ieee_pkg::*;

    localparam logic [Ne:0] EXP_ONE = {{Ne{1'b0}}, 1'b1};

    state_t           state_q;
    logic             s_q;
    logic [Ne:0]      exp_q;
    logic [Nm:0]      mant_q;
    logic [Ne+Nm:0]   out_data_q;
    logic             out_zero_q, out_ovf_q, out_unf_q;

    logic             mant_zero, exp_le0, exp_ovf, exp_one, hidden;
    logic             do_shift;
    fmt_sel_t         sel_d;
    logic [Ne+Nm:0]   word_d;
    logic             zero_d, ovf_d, unf_d;

    assign mant_zero = (mant_q == '0);
    assign exp_le0   = exp_q[Ne] | (exp_q == '0);
    // Signed exponent >= 2^Ne-1 only happens with sign clear and low bits all ones
    assign exp_ovf   = ~exp_q[Ne] & (&exp_q[Ne-1:0]);
    assign exp_one   = (exp_q == EXP_ONE);
    assign hidden    = mant_q[Nm];

    always_comb begin
        do_shift = 1'b0;
        sel_d    = FMT_NORMAL;
        if (mant_zero)
            sel_d = FMT_ZERO;
        else if (exp_le0)
            sel_d = FMT_FLUSH;
        else if (exp_ovf)
            sel_d = FMT_INF;
        else if (!hidden) begin
            if (exp_one)
                sel_d = FMT_DENORM;
            else
                do_shift = 1'b1;
        end
    end

    float_ieee_fmt #(.Nm(Nm), .Ne(Ne)) u_fmt (
        .s_i    (s_q),
        .exp_i  (exp_q[Ne-1:0]),
        .frac_i (mant_q[Nm-1:0]),
        .sel_i  (sel_d),
        .word_o (word_d),
        .zero_o (zero_d),
        .ovf_o  (ovf_d),
        .unf_o  (unf_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            s_q        <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            out_data_q <= '0;
            out_zero_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_unf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        s_q     <= in_data[Nm+Ne+2];
                        exp_q   <= in_data[Nm+Ne+1:Nm+1];
                        mant_q  <= in_data[Nm:0];
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (do_shift) begin
                        mant_q <= {mant_q[Nm-1:0], 1'b0};
                        exp_q  <= exp_q - EXP_ONE;
                    end else begin
                        out_data_q <= word_d;
                        out_zero_q <= zero_d;
                        out_ovf_q  <= ovf_d;
                        out_unf_q  <= unf_d;
                        state_q    <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_float_to_ieee.sv
// Bench for float_to_ieee: directed vector table, backpressure and reset
// sequences, then random operands against an arithmetic reference model.
module tb_float_to_ieee;
    import float_to_ieee_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [33:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_zero, out_ovf, out_unf;

    int total = 0;
    int bad   = 0;

    float_to_ieee dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        s;
        logic [8:0]  e;
        logic [23:0] m;
        logic [31:0] word;
        logic        z;
        logic        o;
        logic        u;
        logic [7:0]  lat;
    } rec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference from the conversion rules in plain integer arithmetic.
    function automatic rec_t model(input logic s, input logic [8:0] e9, input logic [23:0] m);
        rec_t   r;
        int     e;
        longint mm;
        int     k;
        e  = int'($signed(e9));
        mm = longint'(m);
        k  = 0;
        r  = '0;
        r.s = s; r.e = e9; r.m = m;
        if (mm == 0) begin
            r.word = {s, 31'b0}; r.z = 1'b1;
        end else if (e <= 0) begin
            r.word = {s, 31'b0}; r.z = 1'b1; r.u = 1'b1;
        end else if (e >= EXP_MAX) begin
            r.word = {s, 8'hFF, 23'b0}; r.o = 1'b1;
        end else begin
            while (mm < (64'd1 << 23) && e > 1) begin
                mm = mm * 2;
                e  = e - 1;
                k++;
            end
            if (mm < (64'd1 << 23)) begin
                r.word = {s, 8'h00, mm[22:0]}; r.u = 1'b1;
            end else begin
                r.word = {s, e[7:0], mm[22:0]};
            end
        end
        r.lat = 8'(k + 1);
        return r;
    endfunction

    // Apply one operand, check latency/result, hold out_ready low for 'hold' cycles.
    task automatic run_op(input rec_t r, input int hold, input string tag);
        int   n;
        bit   got;
        float_t f;
        @(negedge clk);
        f = '{s: r.s, exp: r.e, mant: r.m};
        in_data  = f;
        in_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (in_ready) got = 1;
            else @(negedge clk);
        end
        chk({tag, " accept"}, 64'(got), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = '0;
        n = 0; got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (i > 0 || n > 0) ;
            @(posedge clk);
            n++;
            #1 if (out_valid) got = 1;
        end
        chk({tag, " latency"}, 64'(got ? n : -1), 64'(r.lat));
        chk({tag, " data"}, 64'(out_data), 64'(r.word));
        chk({tag, " flags"}, 64'({out_zero, out_ovf, out_unf}), 64'({r.z, r.o, r.u}));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 34'h2_5555_5555;
            @(posedge clk);
            #1;
            chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold data"}, 64'({out_data, out_zero, out_ovf, out_unf}),
                64'({r.word, r.z, r.o, r.u}));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, " release in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " release valid"}, 64'(out_valid), 64'd0);
    endtask

    rec_t vec [11];
    rec_t rr;

    initial begin
        // s, exp, mant, word, zero, ovf, unf, edges-to-valid
        vec[0]  = '{1'b0, 9'd127,  24'h800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 8'd1};
        vec[1]  = '{1'b1, 9'd130,  24'h200000, 32'hC0000000, 1'b0, 1'b0, 1'b0, 8'd3};
        vec[2]  = '{1'b0, 9'd100,  24'h000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 8'd1};
        vec[3]  = '{1'b1, 9'd100,  24'h000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 8'd1};
        // 300 does not fit a 9-bit signed exponent; 255 is the largest overflowing value
        vec[4]  = '{1'b0, 9'd255,  24'h800000, 32'h7F800000, 1'b0, 1'b1, 1'b0, 8'd1};
        vec[5]  = '{1'b0, 9'd2,    24'h100000, 32'h00200000, 1'b0, 1'b0, 1'b1, 8'd2};
        vec[6]  = '{1'b0, 9'h1FD,  24'h800000, 32'h00000000, 1'b1, 1'b0, 1'b1, 8'd1};
        vec[7]  = '{1'b0, 9'd0,    24'h800000, 32'h00000000, 1'b1, 1'b0, 1'b1, 8'd1};
        vec[8]  = '{1'b1, 9'd1,    24'h800000, 32'h80800000, 1'b0, 1'b0, 1'b0, 8'd1};
        vec[9]  = '{1'b0, 9'd254,  24'hFFFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0, 8'd1};
        vec[10] = '{1'b0, 9'd24,   24'h000001, 32'h00800000, 1'b0, 1'b0, 1'b0, 8'd24};

        #12;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", 64'({out_data, out_zero, out_ovf, out_unf}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_op(vec[i], 0, $sformatf("vec%0d", i));

        // backpressure, then two operands back to back in order
        run_op(vec[0], 5, "bp");
        run_op(vec[1], 0, "b2b0");
        run_op(vec[5], 0, "b2b1");

        // reset while normalising the two-shift operand
        @(negedge clk);
        in_data  = {vec[1].s, vec[1].e, vec[1].m};
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("mid accept", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort outputs", 64'({out_data, out_zero, out_ovf, out_unf}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(vec[0], 0, "post_reset");

        // random operands, many unnormalised, with edge-heavy exponents
        for (int i = 0; i < 200; i++) begin
            logic        s;
            logic [8:0]  e;
            logic [23:0] m;
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0: e = 9'($urandom);
                1: e = 9'($urandom_range(0, 30));
                2: e = 9'($urandom_range(240, 260));
                default: e = 9'($urandom_range(100, 150));
            endcase
            m = 24'($urandom) >> $urandom_range(0, 24);
            rr = model(s, e, m);
            run_op(rr, (i % 17 == 0) ? 2 : 0, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
